rv_lsu: RTL and testbench

Load/store unit for the rv32i pipeline: the initiator side of the data-memory port. It accepts one load or store request at a time from the MEM stage and drives the word-addressed, byte-strobed data memory. Misaligned halfword and word accesses are split into two word accesses. Load data is sign- or zero-extended, and the result is returned on a one-cycle response pulse.

---
 rtl/rv_lsu.sv | 170 +++++++++++++++++
 tb/tb_rv_lsu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - RV32I load/store unit driving a word-addressed, byte-strobed data memory
// Misaligned accesses that straddle a word are split into two word accesses.
module rv_lsu #(
  parameter int XLEN          = 32,
  parameter int DMEM_ADDR_BIT = 12
) (
  input  logic                     i_lsu_clk,
  input  logic                     i_lsu_rstn,
  input  logic                     i_lsu_req_valid,
  output logic                     o_lsu_req_ready,
  input  logic                     i_lsu_req_we,
  input  logic [2:0]               i_lsu_req_funct3,
  input  logic [XLEN-1:0]          i_lsu_req_addr,
  input  logic [XLEN-1:0]          i_lsu_req_wdata,
  output logic                     o_lsu_resp_valid,
  output logic [XLEN-1:0]          o_lsu_resp_rdata,
  output logic                     o_lsu_resp_err,
  output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
  output logic                     o_dmem_wen,
  output logic [XLEN/8-1:0]        o_dmem_wstrb,
  output logic [XLEN-1:0]          o_dmem_wdata,
  input  logic [XLEN-1:0]          i_dmem_rdata
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t                   state, state_next;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [DMEM_ADDR_BIT-1:0] addr_q;
  logic [XLEN-1:0]          wdata_q, lo_q, rdata_q;
  logic                     err_q;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic            req_f3_ok, req_legal;
  logic [XLEN:0]   req_end;

  always_comb begin
    case (i_lsu_req_funct3)
      3'b000, 3'b001, 3'b010: req_f3_ok = 1'b1;
      3'b100, 3'b101:         req_f3_ok = !i_lsu_req_we;
      default:                req_f3_ok = 1'b0;
    endcase
    // One past the last byte must not exceed the memory size; no wrap to word 0.
    req_end   = {1'b0, i_lsu_req_addr} + (XLEN+1)'(size_of(i_lsu_req_funct3[1:0]));
    req_legal = req_f3_ok && (req_end <= (XLEN+1)'(2**DMEM_ADDR_BIT));
  end

  logic [1:0]               k;
  logic [2:0]               size_q;
  logic                     crossing;
  logic [NB-1:0]            bmask;
  logic [2*NB-1:0]          strb2;
  logic [XLEN-1:0]          wmasked, rd_sh, load_res;
  logic [2*XLEN-1:0]        lanes2, rd2;
  logic [DMEM_ADDR_BIT-3:0] word;

  always_comb begin
    k        = addr_q[1:0];
    word     = addr_q[DMEM_ADDR_BIT-1:2];
    size_q   = size_of(f3_q[1:0]);
    crossing = ({1'b0, k} + size_q) > 3'd4;
    case (f3_q[1:0])
      2'b00:   bmask = NB'(1);
      2'b01:   bmask = NB'(3);
      default: bmask = {NB{1'b1}};
    endcase
    wmasked = '0;
    for (int b = 0; b < NB; b++) wmasked[8*b +: 8] = wdata_q[8*b +: 8] & {8{bmask[b]}};
    strb2  = {{NB{1'b0}}, bmask} << k;
    lanes2 = {{XLEN{1'b0}}, wmasked} << {k, 3'b000};
    // The high word only exists once ACC2 is reached; a non-crossing load sees zeros there.
    rd2    = (state == ACC2) ? {i_dmem_rdata, lo_q} : {{XLEN{1'b0}}, i_dmem_rdata};
    rd_sh  = XLEN'(rd2 >> {k, 3'b000});
    case (f3_q)
      3'b000:  load_res = {{(XLEN-8){rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  load_res = {{(XLEN-16){rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  load_res = {{(XLEN-8){1'b0}}, rd_sh[7:0]};
      3'b101:  load_res = {{(XLEN-16){1'b0}}, rd_sh[15:0]};
      default: load_res = rd_sh;
    endcase
  end

  always_comb begin
    state_next       = state;
    o_lsu_req_ready  = 1'b0;
    o_lsu_resp_valid = 1'b0;
    o_dmem_addr      = '0;
    o_dmem_wen       = 1'b0;
    o_dmem_wstrb     = '0;
    o_dmem_wdata     = '0;
    case (state)
      IDLE: begin
        o_lsu_req_ready = 1'b1;
        if (i_lsu_req_valid) state_next = req_legal ? ACC1 : DONE;
      end
      ACC1: begin
        state_next   = crossing ? ACC2 : DONE;
        o_dmem_addr  = word;
        o_dmem_wen   = we_q;
        o_dmem_wstrb = we_q ? strb2[NB-1:0] : '0;
        o_dmem_wdata = we_q ? lanes2[XLEN-1:0] : '0;
      end
      ACC2: begin
        state_next   = DONE;
        o_dmem_addr  = word + (DMEM_ADDR_BIT-2)'(1);
        o_dmem_wen   = we_q;
        o_dmem_wstrb = we_q ? strb2[2*NB-1:NB] : '0;
        o_dmem_wdata = we_q ? lanes2[2*XLEN-1:XLEN] : '0;
      end
      DONE: begin
        state_next       = IDLE;
        o_lsu_resp_valid = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
    if (!i_lsu_rstn) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (i_lsu_req_valid) begin
          we_q    <= i_lsu_req_we;
          f3_q    <= i_lsu_req_funct3;
          addr_q  <= i_lsu_req_addr[DMEM_ADDR_BIT-1:0];
          wdata_q <= i_lsu_req_wdata;
          if (!req_legal) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ACC1: begin
          lo_q <= i_dmem_rdata;
          if (!crossing) begin
            rdata_q <= we_q ? '0 : load_res;
            err_q   <= 1'b0;
          end
        end
        ACC2: begin
          rdata_q <= we_q ? '0 : load_res;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_lsu_resp_rdata = rdata_q;
  assign o_lsu_resp_err   = err_q;

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - self-checking bench for rv_lsu against a byte-level memory model
module tb_rv_lsu;
  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_wen;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata, dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  rv_lsu #(.XLEN(32), .DMEM_ADDR_BIT(12)) dut (
    .i_lsu_clk(clk), .i_lsu_rstn(rst_n),
    .i_lsu_req_valid(req_valid), .o_lsu_req_ready(req_ready),
    .i_lsu_req_we(req_we), .i_lsu_req_funct3(req_funct3),
    .i_lsu_req_addr(req_addr), .i_lsu_req_wdata(req_wdata),
    .o_lsu_resp_valid(resp_valid), .o_lsu_resp_rdata(resp_rdata), .o_lsu_resp_err(resp_err),
    .o_dmem_addr(dmem_addr), .o_dmem_wen(dmem_wen), .o_dmem_wstrb(dmem_wstrb),
    .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with a backdoor write port used only while the LSU is idle.
  logic [31:0] dmem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) dmem[bd_addr] <= bd_data;
    else if (dmem_wen)
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) dmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
  end
  assign dmem_rdata = dmem[dmem_addr];

  // Reference: flat byte array, little-endian.
  logic [7:0] ref_mem [0:4095];

  function automatic int ref_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    bit ok;
    ok = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return ok && (longint'(addr) + longint'(ref_size(f3)) <= 64'd4096);
  endfunction

  function automatic bit ref_cross(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr % 4) + ref_size(f3)) > 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < ref_size(f3); i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    if (we && ref_legal(we, f3, addr))
      for (int i = 0; i < ref_size(f3); i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic poke(input int w, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = w[9:0]; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[4*w+b] = d[8*b +: 8];
  endtask

  // Observations from the most recent request.
  logic [31:0] r_rdata;
  logic        r_err, r_ready_ok, r_pulse_ok;
  int          r_lat, r_nwr;
  logic [9:0]  acc_addr  [2];
  logic [3:0]  acc_strb  [2];
  logic [31:0] acc_wdata [2];

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold);
    @(negedge clk);
    r_ready_ok = (req_ready === 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = hold;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom_range(0, 4095); req_wdata = $urandom;
    r_lat = -1; r_nwr = 0; r_pulse_ok = 1'b0;
    for (int c = 1; c <= 8 && r_lat < 0; c++) begin
      @(negedge clk);
      if (dmem_wen === 1'b1) begin
        if (r_nwr < 2) begin
          acc_addr[r_nwr] = dmem_addr; acc_strb[r_nwr] = dmem_wstrb; acc_wdata[r_nwr] = dmem_wdata;
        end
        r_nwr++;
      end
      if (resp_valid === 1'b1) begin
        r_lat = c; r_rdata = resp_rdata; r_err = resp_err; req_valid = 1'b0;
      end else if (req_ready !== 1'b0) r_ready_ok = 1'b0;
    end
    req_valid = 1'b0;
    if (r_lat > 0) begin
      @(negedge clk);
      r_pulse_ok = (resp_valid === 1'b0) && (req_ready === 1'b1) && (dmem_wen === 1'b0) &&
                   (resp_rdata === r_rdata) && (resp_err === r_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp: rdata %h err %b want 0 0", resp_rdata, resp_err); end
    n_checks++; if (dmem_addr !== 10'h0 || dmem_wen !== 1'b0 || dmem_wstrb !== 4'h0 || dmem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_dmem: addr %h wen %b strb %b wdata %h want all 0", dmem_addr, dmem_wen, dmem_wstrb, dmem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0); ref_store(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    n_checks++; if (r_nwr !== 1 || acc_addr[0] !== 10'd4 || acc_strb[0] !== 4'b1111 || acc_wdata[0] !== 32'hDEADBEEF || r_lat !== 2) begin
      n_fail++; $display("FAIL sw_aligned: nwr %0d addr %0d strb %b wdata %h lat %0d want 1 4 1111 deadbeef 2", r_nwr, acc_addr[0], acc_strb[0], acc_wdata[0], r_lat); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0 || r_lat !== 2 || !r_pulse_ok) begin
      n_fail++; $display("FAIL lw_aligned: rdata %h err %b lat %0d pulse %b want deadbeef 0 2 1", r_rdata, r_err, r_lat, r_pulse_ok); end

    poke(0, 32'h80FF7F01);
    do_req(1'b0, 3'b000, 32'h2, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL lb_sign: got %h want ffffffff", r_rdata); end
    do_req(1'b0, 3'b100, 32'h3, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", r_rdata); end
    do_req(1'b0, 3'b001, 32'h2, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_sign: got %h want ffff80ff", r_rdata); end
    do_req(1'b1, 3'b000, 32'h1, 32'h123456AA, 1'b0); ref_store(1'b1, 3'b000, 32'h1, 32'h123456AA);
    n_checks++; if (acc_strb[0] !== 4'b0010 || acc_wdata[0] !== 32'h0000AA00 || r_nwr !== 1) begin
      n_fail++; $display("FAIL sb_lane: strb %b wdata %h nwr %0d want 0010 0000aa00 1", acc_strb[0], acc_wdata[0], r_nwr); end

    do_req(1'b1, 3'b010, 32'h13, 32'h11223344, 1'b0); ref_store(1'b1, 3'b010, 32'h13, 32'h11223344);
    n_checks++; if (r_nwr !== 2 || acc_addr[0] !== 10'd4 || acc_strb[0] !== 4'b1000 || acc_wdata[0] !== 32'h44000000 ||
                    acc_addr[1] !== 10'd5 || acc_strb[1] !== 4'b0111 || acc_wdata[1] !== 32'h00112233 || r_lat !== 3) begin
      n_fail++; $display("FAIL sw_split: nwr %0d a0 %0d s0 %b d0 %h a1 %0d s1 %b d1 %h lat %0d", r_nwr, acc_addr[0], acc_strb[0], acc_wdata[0], acc_addr[1], acc_strb[1], acc_wdata[1], r_lat); end
    do_req(1'b0, 3'b010, 32'h13, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h11223344 || r_lat !== 3 || !r_pulse_ok) begin
      n_fail++; $display("FAIL lw_split: rdata %h lat %0d pulse %b want 11223344 3 1", r_rdata, r_lat, r_pulse_ok); end

    poke(1, 32'hAB000000); poke(2, 32'h000000CD);
    do_req(1'b0, 3'b101, 32'h7, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'h0000CDAB || r_lat !== 3) begin n_fail++; $display("FAIL lhu_split: got %h lat %0d want 0000cdab 3", r_rdata, r_lat); end
    do_req(1'b0, 3'b001, 32'h7, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== 32'hFFFFCDAB) begin n_fail++; $display("FAIL lh_split: got %h want ffffcdab", r_rdata); end
  endtask

  task automatic test_illegal;
    logic        iwe [3];
    logic [2:0]  if3 [3];
    logic [31:0] iad [3];
    iwe[0] = 1'b0; if3[0] = 3'b010; iad[0] = 32'd4094;
    iwe[1] = 1'b0; if3[1] = 3'b011; iad[1] = 32'h20;
    iwe[2] = 1'b1; if3[2] = 3'b000; iad[2] = 32'd4096;
    for (int i = 0; i < 3; i++) begin
      do_req(iwe[i], if3[i], iad[i], 32'hFFFFFFFF, 1'b0);
      n_checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0 || r_nwr !== 0 || r_lat !== 1 || !r_pulse_ok) begin
        n_fail++; $display("FAIL illegal_%0d: err %b rdata %h nwr %0d lat %0d pulse %b want 1 0 0 1 1", i, r_err, r_rdata, r_nwr, r_lat, r_pulse_ok); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] wd;
    bit          saw;
    wd = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h21; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (dmem_wen !== 1'b1 || dmem_addr !== 10'd9) begin n_fail++; $display("FAIL mid_acc2: wen %b addr %0d want 1 9", dmem_wen, dmem_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_wen !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_idle: ready %b resp %b wen %b want 1 0 0", req_ready, resp_valid, dmem_wen); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) if ((32'h21 + i) / 4 == 32'h21 / 4) ref_mem[32'h21 + i] = wd[8*i +: 8];
    saw = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw) begin n_fail++; $display("FAIL mid_no_resp: resp_valid pulsed, want none"); end
    n_checks++; if (dmem[8] !== ref_word(8) || dmem[9] !== ref_word(9)) begin
      n_fail++; $display("FAIL mid_mem: w8 %h w9 %h want %h %h", dmem[8], dmem[9], ref_word(8), ref_word(9)); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    n_checks++; if (r_rdata !== ref_load(3'b010, 32'h20) || r_lat !== 2 || !r_ready_ok) begin
      n_fail++; $display("FAIL mid_after: rdata %h lat %0d ready %b want %h 2 1", r_rdata, r_lat, r_ready_ok, ref_load(3'b010, 32'h20)); end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wd, exp_rd;
    int          sel, exp_lat, exp_nwr, bad;
    bit          legal;
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom); f3 = 3'($urandom); wd = $urandom; sel = $urandom_range(0, 9);
      addr = (sel < 5) ? $urandom_range(0, 63) : (sel < 8) ? $urandom_range(0, 4095) :
             (sel < 9) ? $urandom_range(4088, 4100) : $urandom;
      legal   = ref_legal(we, f3, addr);
      exp_rd  = (legal && !we) ? ref_load(f3, addr) : 32'h0;
      exp_lat = !legal ? 1 : (ref_cross(f3, addr) ? 3 : 2);
      exp_nwr = (legal && we) ? (ref_cross(f3, addr) ? 2 : 1) : 0;
      do_req(we, f3, addr, wd, n[0]);
      ref_store(we, f3, addr, wd);
      n_checks++; if (r_rdata !== exp_rd || r_err !== !legal) begin
        n_fail++; $display("FAIL rand_resp #%0d we %b f3 %b addr %h: rdata %h err %b want %h %b", n, we, f3, addr, r_rdata, r_err, exp_rd, !legal); end
      n_checks++; if (r_lat !== exp_lat || r_nwr !== exp_nwr || !r_ready_ok || !r_pulse_ok) begin
        n_fail++; $display("FAIL rand_timing #%0d: lat %0d nwr %0d ready %b pulse %b want %0d %0d 1 1", n, r_lat, r_nwr, r_ready_ok, r_pulse_ok, exp_lat, exp_nwr); end
    end
    bad = 0;
    for (int w = 0; w < 1024; w++) if (dmem[w] !== ref_word(w)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rand_memory: %0d words differ, want 0", bad); end
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    test_reset();
    for (int w = 0; w < 1024; w++) poke(w, $urandom);
    test_directed();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
